// File: rtl/pong_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pong_pkg
// Purpose  : Shared types and constants for the Pong core: game-flow state
//            encoding, match-winner encoding, playfield grid limits and the
//            default winning score.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package pong_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_PLAY  = 2'b01,
        ST_PAUSE = 2'b10,
        ST_OVER  = 2'b11
    } state_t;

    typedef enum logic [1:0] {
        WIN_NONE = 2'b00,
        WIN_P1   = 2'b01,
        WIN_P2   = 2'b10,
        WIN_DRAW = 2'b11
    } winner_t;

    // Playfield grid limits shared with the ball/bar movers
    localparam int X_LIMIT = 63;
    localparam int Y_LIMIT = 47;

    localparam logic [3:0] DEFAULT_WIN_SCORE = 4'd9;

endpackage : pong_pkg
`default_nettype wire

// File: rtl/frame_divider.sv
`default_nettype none
// ============================================================================
// Module   : frame_divider
// Purpose  : Decodes the once-per-frame raster origin strobe and divides it
//            down by FRAMES_PER_STEP. The counter free-runs regardless of the
//            game state so movement steps stay aligned to a fixed cadence.
// Ports    : clk, reset        - clock / synchronous active-high reset
//            h_count, v_count  - raster position from the VGA timing block
//            tick              - one-cycle pulse on the strobe that wraps
//                                the frame counter (combinational)
// Revision : 1.0 - initial release
// ============================================================================
module frame_divider #(
    parameter int FRAMES_PER_STEP = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [9:0] h_count,
    input  logic [9:0] v_count,
    output logic       tick
);

    // Keep at least one bit so FRAMES_PER_STEP == 1 still elaborates
    localparam int CW = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
    localparam logic [CW-1:0] LAST = CW'(FRAMES_PER_STEP - 1);

    logic          strobe;
    logic [CW-1:0] frame_cnt;

    assign strobe = (h_count == 10'd0) && (v_count == 10'd0);
    assign tick   = strobe && (frame_cnt == LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            frame_cnt <= '0;
        end else if (strobe) begin
            frame_cnt <= (frame_cnt == LAST) ? '0 : frame_cnt + 1'b1;
        end
    end

endmodule : frame_divider
`default_nettype wire

// File: rtl/match_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : match_ctrl
// Purpose  : Game-flow controller for the Pong core. Generates the movement
//            step enable and the game reset pulse for the movers, detects
//            score increments, sequences IDLE/PLAY/PAUSE/OVER and latches
//            the match winner.
// Config   : PAUSE_ON_POINT_EN - when defined, a non-winning point freezes
//            play for PAUSE_STEPS step periods. When undefined the game stays
//            in PLAY after a non-winning point and PAUSE_STEPS is unused.
// Ports    : clk, reset         - clock / synchronous active-high reset
//            start              - level start / restart request
//            h_count, v_count   - raster position (frame strobe source)
//            point1, point2     - player scores from the ball mover
//            step_en            - registered one-cycle movement step pulse
//            game_reset         - registered one-cycle reset to the movers
//            state              - 00 IDLE, 01 PLAY, 10 PAUSE, 11 OVER
//            winner             - 00 none, 01 P1, 10 P2, 11 draw
// Revision : 1.0 - initial release
// ============================================================================
module match_ctrl
    import pong_pkg::*;
#(
    parameter int         FRAMES_PER_STEP = 4,
    parameter int         PAUSE_STEPS     = 30,
    parameter logic [3:0] WIN_SCORE       = DEFAULT_WIN_SCORE
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [9:0] h_count,
    input  logic [9:0] v_count,
    input  logic [3:0] point1,
    input  logic [3:0] point2,
    output logic       step_en,
    output logic       game_reset,
    output logic [1:0] state,
    output logic [1:0] winner
);

    state_t     st;
    winner_t    win_q;
    logic       tick;
    logic [3:0] prev1;
    logic [3:0] prev2;
    logic [3:0] next1;
    logic [3:0] next2;
    logic       inc1;
    logic       inc2;
    logic       win1;
    logic       win2;

`ifdef PAUSE_ON_POINT_EN
    localparam int PW = $clog2(PAUSE_STEPS + 1);
    localparam logic [PW-1:0] PAUSE_LAST = PW'(PAUSE_STEPS - 1);
    logic [PW-1:0] pause_cnt;
`endif

    frame_divider #(
        .FRAMES_PER_STEP (FRAMES_PER_STEP)
    ) u_frame_divider (
        .clk     (clk),
        .reset   (reset),
        .h_count (h_count),
        .v_count (v_count),
        .tick    (tick)
    );

    // An event is only a +1 step (mod 16); resets to 0 or other jumps are
    // absorbed silently into prev.
    assign next1 = prev1 + 4'd1;
    assign next2 = prev2 + 4'd1;
    assign inc1  = (point1 == next1);
    assign inc2  = (point2 == next2);
    assign win1  = inc1 && (point1 == WIN_SCORE);
    assign win2  = inc2 && (point2 == WIN_SCORE);

    assign state  = st;
    assign winner = win_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            st         <= ST_IDLE;
            win_q      <= WIN_NONE;
            step_en    <= 1'b0;
            game_reset <= 1'b0;
            prev1      <= 4'd0;
            prev2      <= 4'd0;
`ifdef PAUSE_ON_POINT_EN
            pause_cnt  <= '0;
`endif
        end else begin
            prev1      <= point1;
            prev2      <= point2;
            game_reset <= 1'b0;
            step_en    <= tick && (st == ST_PLAY);

            case (st)
                ST_IDLE, ST_OVER: begin
                    if (start) begin
                        game_reset <= 1'b1;
                        win_q      <= WIN_NONE;
                        st         <= ST_PLAY;
                    end
                end

                ST_PLAY: begin
                    if (win1 && win2) begin
                        st    <= ST_OVER;
                        win_q <= WIN_DRAW;
                    end else if (win1) begin
                        st    <= ST_OVER;
                        win_q <= WIN_P1;
                    end else if (win2) begin
                        st    <= ST_OVER;
                        win_q <= WIN_P2;
                    end
`ifdef PAUSE_ON_POINT_EN
                    else if (inc1 || inc2) begin
                        st        <= ST_PAUSE;
                        pause_cnt <= '0;
                    end
`endif
                end

`ifdef PAUSE_ON_POINT_EN
                ST_PAUSE: begin
                    // start and score changes are ignored while frozen
                    if (tick) begin
                        pause_cnt <= pause_cnt + 1'b1;
                        if (pause_cnt == PAUSE_LAST) begin
                            st <= ST_PLAY;
                        end
                    end
                end
`endif

                default: begin
                    st <= ST_IDLE;
                end
            endcase
        end
    end

endmodule : match_ctrl
`default_nettype wire

// File: tb/tb_match_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_match_ctrl
// Purpose  : Directed self-checking bench for match_ctrl with default
//            parameters (FRAMES_PER_STEP=4, PAUSE_STEPS=30, WIN_SCORE=9).
//            Frame strobes are produced by parking the raster counters at a
//            nonzero position and pulling both to zero for one clock.
// Revision : 1.0 - initial release
// ============================================================================
module tb_match_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [9:0] h_count;
    logic [9:0] v_count;
    logic [3:0] point1;
    logic [3:0] point2;
    logic       step_en;
    logic       game_reset;
    logic [1:0] state;
    logic [1:0] winner;

    int tests  = 0;
    int failed = 0;
    int fc     = 0;   // model of the free-running frame counter

    always #5 clk = ~clk;

    match_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .h_count    (h_count),
        .v_count    (v_count),
        .point1     (point1),
        .point2     (point2),
        .step_en    (step_en),
        .game_reset (game_reset),
        .state      (state),
        .winner     (winner)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One strobe cycle followed by one quiet cycle. got = step_en sampled
    // after the strobe edge; tk = whether the model expects a wrap tick.
    task automatic do_strobe(output logic got, output logic tk);
        tk = (fc == 3);
        fc = (fc + 1) % 4;
        h_count = 10'd0;
        v_count = 10'd0;
        step();
        got = step_en;
        h_count = 10'd5;
        v_count = 10'd5;
        step();
        check("step_low_after_pulse", {7'd0, step_en}, 8'd0);
    endtask

    initial begin
        logic s;
        logic tk;
        int   pticks;

        reset   = 1'b1;
        start   = 1'b0;
        h_count = 10'd5;
        v_count = 10'd5;
        point1  = 4'd0;
        point2  = 4'd0;
        step();
        step();
        check("rst_state",      {6'd0, state},      8'd0);
        check("rst_step_en",    {7'd0, step_en},    8'd0);
        check("rst_game_reset", {7'd0, game_reset}, 8'd0);
        check("rst_winner",     {6'd0, winner},     8'd0);
        reset = 1'b0;
        step();
        check("idle_hold", {6'd0, state}, 8'd0);

        // One strobe in IDLE: frame counter advances, no step
        do_strobe(s, tk);
        check("idle_no_step", {7'd0, s}, 8'd0);

        // Start: game_reset one clock, PLAY on same edge
        start = 1'b1;
        step();
        check("start_game_reset", {7'd0, game_reset}, 8'd1);
        check("start_state",      {6'd0, state},      8'd1);
        check("start_winner",     {6'd0, winner},     8'd0);
        start = 1'b0;
        step();
        check("game_reset_single", {7'd0, game_reset}, 8'd0);

        // Steps follow the free-running counter (not restarted by start)
        for (int i = 0; i < 8; i++) begin
            do_strobe(s, tk);
            check("play_step", {7'd0, s}, {7'd0, tk});
        end

        // Non-winning point for player 1: 2 -> 3
        point1 = 4'd2;
        step();
        check("jump_no_event", {6'd0, state}, 8'd1);
        point1 = 4'd3;
        step();
`ifdef PAUSE_ON_POINT_EN
        check("point_to_pause", {6'd0, state}, 8'd2);
        start = 1'b1;
        step();
        check("pause_ignores_start_state", {6'd0, state},      8'd2);
        check("pause_ignores_start_gr",    {7'd0, game_reset}, 8'd0);
        start = 1'b0;
        pticks = 0;
        for (int i = 0; i < 200 && pticks < 30; i++) begin
            do_strobe(s, tk);
            if (tk) pticks++;
            check("pause_no_step", {7'd0, s}, 8'd0);
            check("pause_state", {6'd0, state}, (pticks == 30) ? 8'd1 : 8'd2);
        end
        check("pause_tick_count", pticks[7:0], 8'd30);
        tk = 1'b0;
        for (int i = 0; i < 4 && !tk; i++) begin
            do_strobe(s, tk);
            check("resume_step", {7'd0, s}, {7'd0, tk});
        end
`else
        check("point_stays_play", {6'd0, state}, 8'd1);
        do_strobe(s, tk);
        check("play_step_after_point", {7'd0, s}, {7'd0, tk});
`endif

        // Player 2 reaches 9 -> OVER, winner P2
        point2 = 4'd8;
        step();
        point2 = 4'd9;
        step();
        check("p2_win_state",  {6'd0, state},  8'd3);
        check("p2_win_winner", {6'd0, winner}, 8'd2);
        for (int i = 0; i < 4; i++) begin
            do_strobe(s, tk);
            check("over_no_step", {7'd0, s}, 8'd0);
        end
        check("over_winner_hold", {6'd0, winner}, 8'd2);

        // Restart from OVER
        start = 1'b1;
        step();
        check("restart_gr",     {7'd0, game_reset}, 8'd1);
        check("restart_winner", {6'd0, winner},     8'd0);
        check("restart_state",  {6'd0, state},      8'd1);
        step();
        check("start_level_no_repeat", {7'd0, game_reset}, 8'd0);
        start = 1'b0;

        // Scores drop from 5 to 0: no event
        point1 = 4'd5;
        point2 = 4'd5;
        step();
        point1 = 4'd0;
        point2 = 4'd0;
        step();
        step();
        check("drop_no_event", {6'd0, state}, 8'd1);

        // Simultaneous winning points -> draw
        point1 = 4'd8;
        point2 = 4'd8;
        step();
        point1 = 4'd9;
        point2 = 4'd9;
        step();
        check("draw_state",  {6'd0, state},  8'd3);
        check("draw_winner", {6'd0, winner}, 8'd3);

        start = 1'b1;
        step();
        start = 1'b0;
        point1 = 4'd0;
        point2 = 4'd0;
        step();
        check("replay_state", {6'd0, state}, 8'd1);

        // Reset mid-operation
        point1 = 4'd1;
        step();
`ifdef PAUSE_ON_POINT_EN
        check("pause_again", {6'd0, state}, 8'd2);
        pticks = 0;
        for (int i = 0; i < 100 && pticks < 12; i++) begin
            do_strobe(s, tk);
            if (tk) pticks++;
        end
        check("pause_cnt_12", {3'd0, dut.pause_cnt}, 8'd12);
        reset = 1'b1;
        step();
        check("mid_rst_pause_cnt", {3'd0, dut.pause_cnt}, 8'd0);
`else
        check("inc_stays_play", {6'd0, state}, 8'd1);
        reset = 1'b1;
        step();
`endif
        check("mid_rst_state",   {6'd0, state},      8'd0);
        check("mid_rst_step_en", {7'd0, step_en},    8'd0);
        check("mid_rst_gr",      {7'd0, game_reset}, 8'd0);
        check("mid_rst_winner",  {6'd0, winner},     8'd0);
        reset = 1'b0;
        step();
        check("mid_rst_no_gr", {7'd0, game_reset}, 8'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule : tb_match_ctrl
`default_nettype wire
